// File: rtl/fft_adc_slave.sv
`default_nettype none
// ============================================================================
//  Module   : fft_adc_slave
//  Purpose  : Emulates a serial ADC slave. A 16-bit parallel sample is loaded
//             into a pending buffer and shifted out MSB first on SCL falling
//             edges after a configurable null bit, framed by an active-low CS.
//  Revision : 1.0  initial release
// ============================================================================
module fft_adc_slave #(
    parameter int NULL_EDGE   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iLOAD,
    input  logic [15:0] iDATA,
    input  logic        iADC_CS,
    input  logic        iADC_SCL,
    output logic        oADC_DATA,
    output logic        oADC_OE,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oABORT
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_NULLB  = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_TAIL   = 3'd4
    } state_t;

    // Falling-edge number carrying the null bit, and the edge after the LSB.
    localparam logic [4:0] c_null_edge = 5'(NULL_EDGE);
    localparam logic [4:0] c_last_edge = 5'(NULL_EDGE + 17);

    // Bits [SYNC_STAGES-1:0] are the synchronizer chain (bit 0 newest);
    // bit SYNC_STAGES holds the previous synchronized sample for edge detection.
    logic [SYNC_STAGES:0] cs_sync_q,  cs_sync_d;
    logic [SYNC_STAGES:0] scl_sync_q, scl_sync_d;

    state_t      state_q, state_d;
    logic [15:0] pend_q,  pend_d;
    logic [15:0] sh_q,    sh_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic        oe_q,    oe_d;
    logic        data_q,  data_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        abort_q, abort_d;

    logic        cs_fall;
    logic        cs_rise;
    logic        scl_fall;
    logic [4:0]  cnt_inc;

    // Synchronizer next-state: shift the raw pins into the chains.
    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-1:0],  iADC_CS};
        scl_sync_d = {scl_sync_q[SYNC_STAGES-1:0], iADC_SCL};
    end

    // Synchronizer registers; idle level of both lines is high.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cs_sync_q  <= '1;
            scl_sync_q <= '1;
        end else begin
            cs_sync_q  <= cs_sync_d;
            scl_sync_q <= scl_sync_d;
        end
    end

    assign cs_fall  =  cs_sync_q[SYNC_STAGES]  & ~cs_sync_q[SYNC_STAGES-1];
    assign cs_rise  = ~cs_sync_q[SYNC_STAGES]  &  cs_sync_q[SYNC_STAGES-1];
    assign scl_fall =  scl_sync_q[SYNC_STAGES] & ~scl_sync_q[SYNC_STAGES-1];

    // Falling-edge counter saturates instead of wrapping.
    assign cnt_inc = (cnt_q == 5'd31) ? cnt_q : (cnt_q + 5'd1);

    // Frame sequencer: next state, datapath and registered output values.
    always_comb begin
        state_d = state_q;
        pend_d  = iLOAD ? iDATA : pend_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        oe_d    = oe_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Capture uses the buffer as it was before any same-cycle load.
                if (cs_fall) begin
                    state_d = ST_SAMPLE;
                    sh_d    = pend_q;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    oe_d    = 1'b0;
                    data_d  = 1'b0;
                end
            end

            ST_SAMPLE, ST_NULLB, ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    data_d  = 1'b0;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                end else if (scl_fall) begin
                    cnt_d = cnt_inc;
                    if (state_q == ST_SAMPLE) begin
                        if (cnt_inc == c_null_edge) begin
                            state_d = ST_NULLB;
                            oe_d    = 1'b1;
                            data_d  = 1'b0;
                        end
                    end else if (state_q == ST_NULLB) begin
                        state_d = ST_SHIFT;
                        data_d  = sh_q[15];
                        sh_d    = {sh_q[14:0], 1'b0};
                    end else if (cnt_inc == c_last_edge) begin
                        state_d = ST_TAIL;
                        oe_d    = 1'b0;
                        data_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d  = sh_q[15];
                        sh_d    = {sh_q[14:0], 1'b0};
                    end
                end
            end

            ST_TAIL: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                data_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer and datapath registers.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            pend_q  <= 16'h0000;
            sh_q    <= 16'h0000;
            cnt_q   <= 5'd0;
            oe_q    <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign oADC_DATA = data_q;
    assign oADC_OE   = oe_q;
    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oABORT    = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_adc_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_adc_slave
//  Purpose  : Self-checking bench for fft_adc_slave. A behavioural SPI-style
//             master drives frames; expected frames go into a scoreboard queue
//             and a monitor compares them when the slave reports done/abort.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_adc_slave;

    localparam int NE = 5;
    localparam int S  = 2;
    localparam int FULL_EDGES = NE + 19;   // two extra edges land in the tail

    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RESET = 2;

    logic        iCLK     = 1'b0;
    logic        iRESET   = 1'b0;
    logic        iLOAD    = 1'b0;
    logic [15:0] iDATA    = 16'h0000;
    logic        iADC_CS  = 1'b1;
    logic        iADC_SCL = 1'b1;
    logic        oADC_DATA;
    logic        oADC_OE;
    logic        oBUSY;
    logic        oDONE;
    logic        oABORT;

    fft_adc_slave #(
        .NULL_EDGE   (NE),
        .SYNC_STAGES (S)
    ) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iLOAD     (iLOAD),
        .iDATA     (iDATA),
        .iADC_CS   (iADC_CS),
        .iADC_SCL  (iADC_SCL),
        .oADC_DATA (oADC_DATA),
        .oADC_OE   (oADC_OE),
        .oBUSY     (oBUSY),
        .oDONE     (oDONE),
        .oABORT    (oABORT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int          kind;
        logic [15:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic        obs[$];       // bits seen by the master on SCL rising edges
    logic        rise_bit;
    logic [15:0] model_buf;    // reference: last value loaded (0 after reset)
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        iLOAD = 1'b1;
        iDATA = v;
        cyc(1);
        iLOAD = 1'b0;
        model_buf = v;
    endtask

    // One master frame. kind selects normal end, abort by CS rise after the
    // last edge, or asynchronous reset after the last falling edge.
    task automatic run_frame(input int nedges, input int h, input int kind,
                             input bit ld_det, input logic [15:0] ld_val);
        exp_t ex;
        if (kind != K_RESET) begin
            ex.kind = kind;
            ex.word = model_buf;
            exp_q.push_back(ex);
        end
        iADC_CS = 1'b0;
        for (int i = 1; i <= S + 1; i++) begin
            cyc(1);
            chk("busy_latency", {31'd0, oBUSY}, (i == S + 1) ? 32'd1 : 32'd0);
            if (ld_det && i == S) begin
                iLOAD = 1'b1;
                iDATA = ld_val;
            end
            if (ld_det && i == S + 1) begin
                iLOAD = 1'b0;
                model_buf = ld_val;
            end
        end
        cyc(4);
        for (int e = 1; e <= nedges; e++) begin
            iADC_SCL = 1'b0;
            cyc(h);
            if (kind == K_RESET && e == nedges) begin
                chk("oe_before_reset", {31'd0, oADC_OE}, 32'd1);
                #2;
                iRESET = 1'b0;
                #1;
                chk("reset_oe", {31'd0, oADC_OE}, 32'd0);
                chk("reset_busy", {31'd0, oBUSY}, 32'd0);
                iADC_CS  = 1'b1;
                iADC_SCL = 1'b1;
                cyc(2);
                iRESET = 1'b1;
                model_buf = 16'h0000;
                cyc(S + 3);
                chk("post_reset_busy", {31'd0, oBUSY}, 32'd0);
                chk("post_reset_oe", {31'd0, oADC_OE}, 32'd0);
                cyc(4);
                return;
            end
            iADC_SCL = 1'b1;
            cyc(h);
        end
        if (kind == K_DONE) begin
            chk("tail_oe", {31'd0, oADC_OE}, 32'd0);
            chk("tail_busy", {31'd0, oBUSY}, 32'd1);
        end
        iADC_CS = 1'b1;
        cyc(S + 1);
        chk("end_oe", {31'd0, oADC_OE}, 32'd0);
        chk("end_busy", {31'd0, oBUSY}, 32'd0);
        cyc(5);
    endtask

    // Master sampler: record bits on SCL rise, clear at the start of a frame.
    always @(negedge iADC_CS) obs.delete();

    always @(posedge iADC_SCL) begin
        if (oADC_OE === 1'b1) begin
            obs.push_back(oADC_DATA);
            rise_bit = oADC_DATA;
        end
    end

    // Data must not have moved between the rising edge and the next fall.
    always @(negedge iADC_SCL) begin
        if (oADC_OE === 1'b1 && obs.size() > 0)
            chk("hold_over_high", {31'd0, oADC_DATA}, {31'd0, rise_bit});
    end

    // Scoreboard monitor: pop one expectation per done/abort pulse.
    always @(negedge iCLK) begin
        if (oDONE === 1'b1 || oABORT === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, oDONE, oABORT}, 32'd0);
            end else begin
                exp_t        ex;
                logic [15:0] w;
                ex = exp_q.pop_front();
                chk("both_pulses", {31'd0, oDONE & oABORT}, 32'd0);
                chk("pulse_kind", oABORT ? K_ABORT : K_DONE, ex.kind);
                if (oDONE === 1'b1) begin
                    chk("bit_count", obs.size(), 32'd17);
                    if (obs.size() == 17) begin
                        chk("null_bit", {31'd0, obs[0]}, 32'd0);
                        w = 16'h0000;
                        for (int i = 1; i <= 16; i++) w = {w[14:0], obs[i]};
                        chk("frame_word", {16'd0, w}, {16'd0, ex.word});
                    end
                end
            end
        end
    end

    initial begin
        model_buf = 16'h0000;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_oe",    {31'd0, oADC_OE},   32'd0);
        chk("rst_data",  {31'd0, oADC_DATA}, 32'd0);
        chk("rst_busy",  {31'd0, oBUSY},     32'd0);
        chk("rst_done",  {31'd0, oDONE},     32'd0);
        chk("rst_abort", {31'd0, oABORT},    32'd0);
        iRESET = 1'b1;
        cyc(3);

        // Basic frame, then alternating and all-ones back to back.
        load(16'hA5C3);
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);
        load(16'hAAAA);
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);
        load(16'hFFFF);
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);

        // Abort after edge 10, then the same sample goes out again.
        load(16'h5A3C);
        run_frame(10, S + 4, K_ABORT, 1'b0, 16'h0);
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);

        // Load while shifting: current frame keeps BEEF, next gets 1234.
        load(16'hBEEF);
        fork
            run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);
            begin
                cyc(120);
                load(16'h1234);
            end
        join
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);

        // Load on the CS-fall detection cycle: old value now, new value next.
        load(16'h0F0F);
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b1, 16'hC3C3);
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);

        // Reset at edge 12; the next frame carries the cleared buffer.
        load(16'h7777);
        run_frame(12, S + 4, K_RESET, 1'b0, 16'h0);
        run_frame(FULL_EDGES, S + 4, K_DONE, 1'b0, 16'h0);

        // Random samples and SCL rates.
        for (int n = 0; n < 10; n++) begin
            logic [15:0] v;
            int          h;
            v = 16'($urandom);
            h = int'($urandom_range(S + 4, S + 2));
            load(v);
            run_frame(FULL_EDGES, h, K_DONE, 1'b0, 16'h0);
        end

        cyc(10);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_adc_slave.md
FFT_ADC_SLAVE -- requirements
Module: fft_adc_slave

Interface
REQ-001 Parameter NULL_EDGE, default 5: index of the SCL falling edge after CS low on which the null bit (0) is driven.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth applied to iADC_CS and iADC_SCL, legal range 2..3.
REQ-003 Port iCLK  input  1  system clock; every register is clocked on its rising edge.
REQ-004 Port iRESET  input  1  reset, asynchronous, active-low.
REQ-005 Port iLOAD  input  1  single-cycle strobe; write iDATA into the pending sample buffer.
REQ-006 Port iDATA  input  16  parallel sample to be serialized, unsigned.
REQ-007 Port iADC_CS  input  1  chip select from the ADC master, active-low, asynchronous to iCLK.
REQ-008 Port iADC_SCL  input  1  serial clock from the ADC master, asynchronous to iCLK.
REQ-009 Port oADC_DATA  output  1  serial data bit; meaningful only while oADC_OE=1.
REQ-010 Port oADC_OE  output  1  output enable; 0 means the line is treated as high-Z.
REQ-011 Port oBUSY  output  1  high from CS-low detection until end of frame or abort.
REQ-012 Port oDONE  output  1  one-cycle pulse after the LSB has been driven for a full SCL period.
REQ-013 Port oABORT  output  1  one-cycle pulse when CS rises before oDONE.

Function
REQ-014 The block SHALL pass iADC_CS and iADC_SCL through SYNC_STAGES flops each, then detect CS fall/rise and SCL fall/rise from the last two synchronized samples.
REQ-015 Effects of a detected pin edge SHALL appear on the outputs exactly SYNC_STAGES+1 iCLK cycles after the pin transition; the master must hold each SCL level at least SYNC_STAGES+2 iCLK cycles.
REQ-016 States: IDLE, SAMPLE, NULLB, SHIFT, TAIL.
REQ-017 IDLE: oADC_OE=0; on CS fall -> SAMPLE, copy pending buffer into the shift register, clear the SCL falling-edge counter, set oBUSY.
REQ-018 SAMPLE: count SCL falling edges; on falling edge number NULL_EDGE -> NULLB with oADC_OE=1, oADC_DATA=0.
REQ-019 NULLB: on the next SCL falling edge -> SHIFT, drive bit 15 of the shift register.
REQ-020 SHIFT: each subsequent SCL falling edge drives the next lower bit (MSB first); the bit driven on falling edge NULL_EDGE+1+k is bit 15-k, k=0..15.
REQ-021 After the falling edge that follows the LSB (edge NULL_EDGE+17) -> TAIL, oADC_OE=0, oDONE pulses once.
REQ-022 TAIL: further SCL edges ignored, output stays high-Z until CS rises; CS rise -> IDLE, oBUSY=0.
REQ-023 SCL rising edges SHALL NOT change oADC_DATA (data is stable for master sampling on the rising edge).
REQ-024 CS rise in SAMPLE, NULLB or SHIFT: -> IDLE next cycle, oADC_OE=0, oBUSY=0, oABORT pulse, no oDONE.
REQ-025 iLOAD in any state SHALL update only the pending buffer; the frame in progress keeps its captured sample, and the next frame uses the last value loaded.
REQ-026 iLOAD on the same cycle as CS-fall detection: the frame SHALL capture the old buffer content; the new value serves the next frame.
REQ-027 The falling-edge counter is 5 bits and saturates at 31; it never wraps.
REQ-028 CS fall detected while not in IDLE (glitch without detected rise) SHALL be ignored.

Reset
REQ-029 On iRESET=0, asynchronously: state IDLE, pending buffer 16'h0000, shift register 0, counter 0, synchronizer flops to CS=1/SCL=1, oADC_OE=0, oADC_DATA=0, oBUSY=0, oDONE=0, oABORT=0.
REQ-030 Reset asserted mid-frame SHALL release the line (oADC_OE=0) immediately without oABORT; after release the block waits for a fresh CS fall.

Verification
REQ-031 Load 16'hA5C3, full 22-edge frame -> null 0 on edge 5, bits 1010010111000011 on edges 6..21, oDONE one pulse, OE low after edge 22.
REQ-032 Frames with 16'hAAAA and 16'hFFFF back to back -> alternating and all-ones patterns bit-exact, oADC_DATA=0 only on the null bit.
REQ-033 CS rises after edge 10 -> oABORT one pulse, OE=0 within SYNC_STAGES+1 cycles, no oDONE; next frame sends the same buffered sample.
REQ-034 iLOAD 16'h1234 during SHIFT of frame carrying 16'hBEEF -> current frame BEEF, next frame 1234.
REQ-035 Reset pulsed at edge 12 -> OE=0 immediately, oBUSY=0, no pulses; following frame sends 16'h0000.
REQ-036 Closed loop with fft_adc as master, 10 random samples -> master output matches loaded data each frame.
